// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped 8N1 UART transmitter for the single-cycle MIPS data-memory
// port. Stores into the 16-byte window push bytes into a small TX FIFO. A
// serializer drains the FIFO onto a registered serial line. Loads return
// status combinationally, so a load completes in the same cycle.
//
// Register map (a[3:2], only while sel is high; a[1:0] ignored):
//   0 TXDATA  write pushes wd[7:0]; reads 0
//   1 STATUS  {24'b0, count[3:0], 1'b0, busy, empty, full}; read-only
//   2 DROPS   reads the 8-bit saturating drop count; any write clears it
//   3 unused  reads 0; writes ignored
//
// Ports:
//   clk    in   1   single clock, rising edge
//   reset  in   1   synchronous, active-high
//   we     in   1   store strobe (MemWrite)
//   a      in  32   byte address (ALUResult)
//   wd     in  32   store data (WriteData)
//   rd     out 32   combinational read data, 0 when sel is low
//   sel    out  1   combinational window select
//   tx     out  1   registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Serializer state
    state_t           r_state;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;

    // FIFO state
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [7:0]       r_drops;

    // Decode and next-state signals
    logic             w_sel;
    logic             w_wr_txdata;
    logic             w_wr_drops;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic             w_baud_last;
    state_t           w_state_nxt;
    logic [15:0]      w_baud_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_tx_nxt;
    logic [3:0]       w_count4;
    logic             w_unused;

    assign w_sel       = (a[31:4] == BASE_ADDR[31:4]);
    assign w_wr_txdata = we && w_sel && (a[3:2] == 2'd0);
    assign w_wr_drops  = we && w_sel && (a[3:2] == 2'd2);
    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != S_IDLE);
    assign w_baud_last = (r_baud == BAUD_LAST);

    // A full FIFO drops the write even when a pop frees a slot this cycle:
    // the decision only looks at the count before the edge.
    assign w_push = w_wr_txdata && !w_full && !reset;
    assign w_drop = w_wr_txdata && w_full;

    // Low address bits and upper store-data bits carry no meaning here.
    assign w_unused = &{1'b0, a[1:0], wd[31:8]};

    // -------------------------------------------------------------------------
    // Serializer next state. tx is registered from the current state, so the
    // line lags the state by one cycle; frames stay adjacent because every
    // state transition is delayed by the same amount.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drops  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            // Push and pop in the same cycle leave the count unchanged.
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_wr_drops) begin
                r_drops <= '0;
            end else if (w_drop && (r_drops != 8'hFF)) begin
                r_drops <= r_drops + 8'd1;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wd[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // Read path, purely combinational from the address and current state
    // -------------------------------------------------------------------------
    assign w_count4 = 4'(r_count);

    always_comb begin
        rd = '0;
        if (w_sel) begin
            unique case (a[3:2])
                2'd1:    rd = {24'd0, w_count4, 1'b0, w_busy, w_empty, w_full};
                2'd2:    rd = {24'd0, r_drops};
                default: rd = '0;
            endcase
        end
    end

    assign sel = w_sel;
    assign tx  = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_mmio
//
// Randomized bench for uart_tx_mmio with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// The reference model works on whole transactions: each accepted byte gets a
// push edge and a pop edge derived from the frame length, from which FIFO
// occupancy, busy, drops and the expected line waveform follow. A monitor on
// the serial line pops expected frames and compares start time and bits.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_mmio;

    localparam int          C     = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * C;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        tx;

    uart_tx_mmio #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .sel  (sel),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        int         fall;
    } frame_t;

    frame_t exp_q[$];
    int     push_e[$];
    int     pop_e[$];
    int     m_drops = 0;

    function automatic int model_count(input int t);
        int c = 0;
        foreach (push_e[i]) if (push_e[i] <= t && pop_e[i] > t) c++;
        return c;
    endfunction

    function automatic bit model_busy(input int t);
        foreach (pop_e[i]) if (pop_e[i] <= t && t < pop_e[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_status(input int t);
        int c = model_count(t);
        return {24'd0, 4'(c), 1'b0, model_busy(t), (c == 0), (c == DEPTH)};
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] addr, input int t);
        if (addr[31:4] != BASE[31:4]) return 32'd0;
        case (addr[3:2])
            2'd1:    return model_status(t);
            2'd2:    return 32'(m_drops);
            default: return 32'd0;
        endcase
    endfunction

    // Store taking effect at rising edge n.
    function automatic void model_store(input logic [31:0] addr, input logic [31:0] data, input int n);
        int p;
        if (reset || addr[31:4] != BASE[31:4]) return;
        case (addr[3:2])
            2'd0: begin
                if (model_count(n - 1) >= DEPTH) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    p = n + 1;
                    if (pop_e.size() > 0 && pop_e[$] + FRAME > p) p = pop_e[$] + FRAME;
                    push_e.push_back(n);
                    pop_e.push_back(p);
                    exp_q.push_back('{data: data[7:0], fall: p + 1});
                end
            end
            2'd2:    m_drops = 0;
            default: ;
        endcase
    endfunction

    function automatic void model_flush();
        push_e.delete();
        pop_e.delete();
        exp_q.delete();
        m_drops = 0;
    endfunction

    // ------------------------------------------------------------------
    // Serial-line monitor
    // ------------------------------------------------------------------
    bit         m_active   = 1'b0;
    bit         m_rst_pend = 1'b0;
    int         m_idx;
    int         m_bad;
    logic [7:0] m_exp;
    logic [7:0] m_got;

    always @(negedge clk) begin
        frame_t f;
        int     b;
        logic   eb;
        if (m_rst_pend) begin
            check_eq("tx_after_reset", {31'd0, tx}, 32'd1);
            m_rst_pend = 1'b0;
        end
        if (reset === 1'b1) begin
            m_active   = 1'b0;
            m_rst_pend = 1'b1;
        end else if (!m_active) begin
            if (tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got start bit at edge %0d expected idle line", cyc);
                    m_active = 1'b1;
                    m_exp    = 8'h00;
                end else begin
                    f = exp_q.pop_front();
                    check_eq("frame_start_edge", cyc, f.fall);
                    m_active = 1'b1;
                    m_exp    = f.data;
                end
                m_idx = 0;
                m_bad = 0;
                m_got = 8'h00;
            end
        end else begin
            m_idx++;
            b  = m_idx / C;
            eb = (b == 0) ? 1'b0 : (b <= 8) ? m_exp[b - 1] : 1'b1;
            if (tx !== eb) m_bad++;
            if ((m_idx % C) == (C / 2) && b >= 1 && b <= 8) m_got[b - 1] = tx;
            if (m_idx == FRAME - 1) begin
                check_eq("frame_data", {24'd0, m_got}, {24'd0, m_exp});
                check_eq("frame_bad_samples", m_bad, 32'd0);
                m_active = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks: each starts and ends 1 unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        model_store(addr, data, cyc + 1);
        step();
        we = 1'b0;
        a  = BASE + 32'd4;
    endtask

    task automatic read_chk(input logic [31:0] addr, input string name);
        logic [31:0] expv;
        we   = 1'b0;
        a    = addr;
        expv = model_rd(addr, cyc);
        @(negedge clk);
        check_eq(name, rd, expv);
        check_eq({name, "_sel"}, {31'd0, sel}, {31'd0, addr[31:4] == BASE[31:4]});
        step();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_active) && t < 3000) begin
            step();
            t++;
        end
        check_eq("drain_in_time", {31'd0, t < 3000}, 32'd1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int          n;
        int          k;
        logic [31:0] addr;
        reset = 1'b1;
        we    = 1'b0;
        a     = BASE + 32'd4;
        wd    = 32'd0;
        model_flush();
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        we = 1'b0;
        a  = BASE + 32'd4;
        @(negedge clk);
        check_eq("reset_status", rd, 32'h0000_0002);
        check_eq("reset_tx", {31'd0, tx}, 32'd1);
        step();
        read_chk(BASE + 32'd12, "reset_unmapped");

        // Single frame
        n = cyc + 1;
        store(BASE, 32'hA5);
        read_chk(BASE + 32'd4, "status_after_push");
        while (cyc < n + FRAME) step();
        read_chk(BASE + 32'd4, "status_end_frame");
        check_eq("status_idle_value", rd, 32'h0000_0002);
        drain();

        // Six consecutive stores into a four-deep FIFO
        for (int i = 0; i < 6; i++) store(BASE, 32'($urandom_range(0, 255)));
        read_chk(BASE + 32'd4, "status_full");
        read_chk(BASE + 32'd8, "drops_one");
        store(BASE + 32'd8, 32'hDEAD_BEEF);
        read_chk(BASE + 32'd8, "drops_cleared");
        drain();

        // Back-to-back frames
        store(BASE, 32'h01);
        store(BASE, 32'h02);
        store(BASE, 32'h03);
        drain();

        // Writes that must not push
        store(BASE + 32'd12, 32'h55);
        store(32'h1234_0000, 32'h66);
        read_chk(32'h1234_0004, "outside_read");
        read_chk(BASE + 32'd0, "txdata_read");
        read_chk(BASE + 32'd4, "status_no_push");
        read_chk(BASE + 32'd8, "drops_unchanged");

        // Randomized bursts
        for (int r = 0; r < 25; r++) begin
            k = $urandom_range(1, 7);
            for (int i = 0; i < k; i++) begin
                case ($urandom_range(0, 9))
                    0:       addr = BASE + 32'd8;
                    1:       addr = BASE + 32'd12;
                    2:       addr = 32'(BASE + $urandom_range(1, 3));
                    3:       addr = 32'h0000_1000;
                    default: addr = BASE;
                endcase
                store(addr, $urandom);
                repeat ($urandom_range(0, 2)) step();
            end
            read_chk(BASE + 32'd4, "rand_status");
            read_chk(BASE + 32'd8, "rand_drops");
            repeat ($urandom_range(0, 60)) step();
        end
        drain();

        // DROPS saturation
        for (int i = 0; i < 300; i++) store(BASE, 32'($urandom_range(0, 255)));
        read_chk(BASE + 32'd8, "drops_saturated");
        check_eq("drops_sat_value", rd, 32'd255);
        store(BASE + 32'd8, 32'd0);
        drain();

        // Reset during DATA bit 3 with two bytes queued
        n = cyc + 1;
        store(BASE, 32'h3C);
        store(BASE, 32'hC3);
        store(BASE, 32'h99);
        while (cyc < n + 17) step();
        read_chk(BASE + 32'd4, "status_before_reset");
        reset = 1'b1;
        model_flush();
        store(BASE, 32'h77);
        reset = 1'b0;
        read_chk(BASE + 32'd4, "status_after_reset");
        check_eq("status_after_reset_value", rd, 32'h0000_0002);
        repeat (3 * FRAME) step();
        read_chk(BASE + 32'd4, "status_quiet");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
